cam_pixel_assembler: RTL and testbench
======================================

Name: cam_pixel_assembler

Overview:
- Sits directly downstream of the falling-edge detector on the camera VSYNC line, and alongside a second detector on HREF.
- Consumes the single-cycle VSYNC falling-edge pulse as frame start.
- Packs the camera's byte stream (two bytes per RGB565 pixel, high byte first) into 16-bit pixels.
- Tags each pixel with x/y coordinates and flags malformed lines and frames for the downstream vision pipeline.

Parameters:
- H_ACTIVE, 640, pixels per valid line.
- V_ACTIVE, 480, lines per valid frame.
- XW, 10, width of pix_x; must satisfy 2^XW > H_ACTIVE.
- YW, 9, width of pix_y; must satisfy 2^YW > V_ACTIVE.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-low reset.
- vsync_fe  in  1  one-cycle pulse on VSYNC falling edge (frame start).
- href  in  1  line-active level from the camera (already synchronised).
- byte_valid  in  1  qualifies cam_byte; asserted at most once per camera PCLK.
- cam_byte  in  8  camera data byte.
- pix_data  out  16  assembled pixel {first byte, second byte}.
- pix_valid  out  1  one-cycle strobe; pix_data/pix_x/pix_y are valid.
- pix_x  out  XW  column of the current pixel, 0..H_ACTIVE-1.
- pix_y  out  YW  row of the current pixel, 0..V_ACTIVE-1.
- frame_start  out  1  one-cycle pulse, registered from vsync_fe.
- line_done  out  1  one-cycle pulse at the end of each in-frame line.
- frame_done  out  1  one-cycle pulse when line V_ACTIVE-1 completes.
- frame_err  out  1  one-cycle pulse on a malformed line or frame.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0; state=WAIT_FRAME; counters, byte phase and href_d cleared.
- Two states:
  - WAIT_FRAME: ignores bytes and href until vsync_fe.
  - ACTIVE: captures bytes.
- vsync_fe in any state:
  - Next cycle: frame_start=1, x=0, y=0, phase=0, state=ACTIVE.
  - If it arrives in ACTIVE with line count != V_ACTIVE, frame_err=1 in the same cycle as frame_start (truncated frame).
- Byte capture (ACTIVE, href=1, byte_valid=1):
  - phase=0: latch byte into hi register; phase becomes 1.
  - phase=1: pix_data={hi,cam_byte}, pix_x=x, pix_y=y, pix_valid=1 on the next cycle; x increments; phase becomes 0.
  - Latency: one cycle from the second byte to pix_valid.
- Overlong line: once x reaches H_ACTIVE, further pixels are discarded (no pix_valid) and the line is marked bad.
- End of line: href falling is detected internally with a registered href_d. On that cycle:
  - line_done pulses next cycle.
  - frame_err pulses if x != H_ACTIVE or phase=1 (odd byte count); the partial byte is dropped.
  - x and phase are cleared; y increments.
  - If the new y == V_ACTIVE: frame_done pulses with line_done; state=WAIT_FRAME.
- Extra lines after frame_done are ignored (state is WAIT_FRAME).
- href high with byte_valid in WAIT_FRAME: ignored, no error.
- Simultaneous events:
  - vsync_fe and byte_valid in the same cycle: vsync_fe wins; the byte is dropped.
  - vsync_fe and href falling edge in the same cycle: vsync_fe wins; no line_done.
- Reset mid-frame: immediate return to reset values; the next valid frame needs a fresh vsync_fe.
- Counter widths: x saturates at H_ACTIVE (no wrap). y never exceeds V_ACTIVE.

Decomposition:
- Shared package cam_pkg:
  - RGB565 pixel typedef (16 bits).
  - Default H_ACTIVE/V_ACTIVE constants.
  - State encoding for WAIT_FRAME/ACTIVE.
- Sub-module cam_byte_pair:
  - Holds the phase bit and hi-byte register.
  - Emits a pair_valid strobe plus 16-bit data.
  - Has a clear input driven by vsync_fe or the href falling edge.
- Top level owns the FSM, x/y counters and the error/flag logic.

Test Plan:
1. Nominal frame (H_ACTIVE=4, V_ACTIVE=2): vsync_fe, then 2 lines of 8 bytes 0x00..0x07 → 4 pix_valid per line; pix_data 0x0001,0x0203,0x0405,0x0607; x 0..3; y 0 then 1; two line_done pulses; frame_done with the second; frame_err never set.
2. Odd byte line: a 7-byte line → 3 pixels, then line_done plus frame_err=1; the next line starts with phase=0 (its first pixel is the bytes 0x00,0x01).
3. Overlong line: 10 bytes with H_ACTIVE=4 → exactly 4 pix_valid; frame_err=1 at href fall; y increments normally.
4. Truncated frame: vsync_fe after only 1 line → frame_start and frame_err in the same cycle; x=y=0; the following 2 good lines give frame_done.
5. Collisions: vsync_fe coincident with byte_valid, and then coincident with href fall → no pix_valid, no line_done, frame_start=1.
6. Async reset: assert reset low mid-line between clock edges → all outputs 0 immediately; bytes after release are ignored until vsync_fe.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and defaults for the camera pixel assembler.
// Pixels are RGB565, arriving high byte first.
package cam_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef logic [15:0] rgb565_t;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        ACTIVE     = 1'b1
    } cam_state_t;

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs consecutive camera bytes into one RGB565 word.
// The first byte of a pair is held; the second byte completes the pixel.
module cam_byte_pair
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       capture,
    input  logic [7:0] cam_byte,
    output logic       pair_valid,
    output rgb565_t    pair_data,
    output logic       phase
);

    logic [7:0] hi;

    // clear outranks capture, so a colliding byte is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase <= 1'b0;
            hi    <= 8'h00;
        end else if (clear) begin
            phase <= 1'b0;
        end else if (capture) begin
            if (!phase) begin
                hi <= cam_byte;
            end
            phase <= ~phase;
        end
    end

    assign pair_valid = capture & phase & ~clear;
    assign pair_data  = {hi, cam_byte};

endmodule

// File: rtl/cam_pixel_assembler.sv
// Frame/line tracker around cam_byte_pair: tags pixels with x/y and
// flags short, long, odd-length lines and truncated frames.
module cam_pixel_assembler
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int XW       = 10,
    parameter int YW       = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vsync_fe,
    input  logic          href,
    input  logic          byte_valid,
    input  logic [7:0]    cam_byte,
    output rgb565_t       pix_data,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic          line_done,
    output logic          frame_done,
    output logic          frame_err
);

    localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);

    cam_state_t    state, state_next;
    logic          href_d;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [YW-1:0] y_inc;
    logic          line_bad;
    logic          in_frame, href_fall, eol, capture, clear;
    logic          pair_valid, phase;
    rgb565_t       pair_data;

    // vsync_fe has priority over every other event in the same cycle
    assign in_frame  = (state == ACTIVE);
    assign href_fall = href_d & ~href;
    assign eol       = in_frame & href_fall & ~vsync_fe;
    assign capture   = in_frame & href & byte_valid & ~vsync_fe;
    assign clear     = vsync_fe | href_fall;
    assign y_inc     = y + 1'b1;

    cam_byte_pair u_pair (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .capture    (capture),
        .cam_byte   (cam_byte),
        .pair_valid (pair_valid),
        .pair_data  (pair_data),
        .phase      (phase)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (vsync_fe) begin
            state_next = ACTIVE;
        end else if (eol && (y_inc == Y_END)) begin
            state_next = WAIT_FRAME;
        end
    end

    // pix_valid is a one-cycle strobe; pix_data/pix_x/pix_y are meaningful only while it is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            href_d      <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_bad    <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            href_d      <= href;
            if (vsync_fe) begin
                frame_start <= 1'b1;
                frame_err   <= in_frame && (y != Y_END);
                x           <= '0;
                y           <= '0;
                line_bad    <= 1'b0;
            end else if (eol) begin
                line_done  <= 1'b1;
                frame_done <= (y_inc == Y_END);
                frame_err  <= (x != X_END) | phase | line_bad;
                x          <= '0;
                y          <= y_inc;
                line_bad   <= 1'b0;
            end else if (pair_valid) begin
                // x parks at X_END; surplus pixels only poison the line
                if (x != X_END) begin
                    pix_valid <= 1'b1;
                    pix_data  <= pair_data;
                    pix_x     <= x;
                    pix_y     <= y;
                    x         <= x + 1'b1;
                end else begin
                    line_bad <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_pixel_assembler.sv
// Directed bench for cam_pixel_assembler with a tiny 4x2 frame; drivers
// queue expected pixels/events and a negedge monitor pops and compares.
module tb_cam_pixel_assembler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int W  = 16 + XW + YW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          vsync_fe = 1'b0;
    logic          href = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    cam_byte = 8'h00;
    logic [15:0]   pix_data;
    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic          frame_start, line_done, frame_done, frame_err;

    cam_pixel_assembler #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW)) dut (
        .clk         (clk),
        .reset       (reset),
        .vsync_fe    (vsync_fe),
        .href        (href),
        .byte_valid  (byte_valid),
        .cam_byte    (cam_byte),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    // clock and reset
    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    logic [3:0]   ev_q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    bit           m_active = 1'b0;
    int           m_y = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        vsync_fe   = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic push_pix(input logic [15:0] d, input int x, input int y);
        exp_q.push_back({d, XW'(x), YW'(y)});
    endtask

    task automatic do_vsync();
        ev_q.push_back({1'b1, 1'b0, 1'b0, (m_active && m_y != V)});
        m_active = 1'b1;
        m_y      = 0;
        vsync_fe = 1'b1;
        step();
    endtask

    task automatic send_bytes(input int n);
        href = 1'b1;
        for (int i = 0; i < n; i++) begin
            cam_byte   = 8'(i);
            byte_valid = 1'b1;
            if (m_active && (i % 2 == 1) && (i / 2 < H))
                push_pix({8'(i - 1), 8'(i)}, i / 2, m_y);
            step();
        end
    endtask

    task automatic send_line(input int n);
        send_bytes(n);
        href = 1'b0;
        if (m_active) begin
            ev_q.push_back({1'b0, 1'b1, (m_y + 1 == V), (n != 2 * H)});
            m_y++;
            if (m_y == V) m_active = 1'b0;
        end
        step();
        step();
    endtask

    // scoreboard monitor
    logic [W-1:0] e_pix;
    logic [3:0]   e_ev, got_ev;
    always @(negedge clk) begin
        if (reset) begin
            if (pix_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pixel: got data=%h x=%0d y=%0d, required no pixel", pix_data, pix_x, pix_y);
                end else begin
                    e_pix = exp_q.pop_front();
                    if ({pix_data, pix_x, pix_y} !== e_pix) begin
                        n_err++;
                        $display("FAIL pixel: got data=%h x=%0d y=%0d, required data=%h x=%0d y=%0d",
                                 pix_data, pix_x, pix_y, e_pix[W-1 -: 16], e_pix[XW+YW-1 -: XW], e_pix[YW-1:0]);
                    end
                end
            end
            got_ev = {frame_start, line_done, frame_done, frame_err};
            if (got_ev != 4'b0000) begin
                n_cmp++;
                if (ev_q.size() == 0) begin
                    n_err++;
                    $display("FAIL event {start,line,frame,err}: got %b, required no event", got_ev);
                end else begin
                    e_ev = ev_q.pop_front();
                    if (got_ev !== e_ev) begin
                        n_err++;
                        $display("FAIL event {start,line,frame,err}: got %b, required %b", got_ev, e_ev);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got no end of test, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_pix_data", 32'(pix_data), 32'h0);
        check("reset_pix_xy", 32'({pix_x, pix_y}), 32'h0);
        check("reset_flags", 32'({pix_valid, frame_start, line_done, frame_done, frame_err}), 32'h0);
        reset = 1'b1;
        step();

        // bytes before any frame start are ignored
        send_line(8);

        // nominal frame
        do_vsync();
        send_line(8);
        send_line(8);

        // odd byte line, then a clean line starting at phase 0
        do_vsync();
        send_line(7);
        send_line(8);

        // overlong line
        do_vsync();
        send_line(10);
        send_line(8);

        // truncated frame restarted after one line
        do_vsync();
        send_line(8);
        do_vsync();
        send_line(8);
        send_line(8);

        // vsync colliding with a byte, then with the href fall
        do_vsync();
        href       = 1'b1;
        cam_byte   = 8'hAA;
        byte_valid = 1'b1;
        step();
        cam_byte   = 8'hBB;
        byte_valid = 1'b1;
        do_vsync();
        send_bytes(4);
        href = 1'b0;
        do_vsync();
        step();
        send_line(8);
        send_line(8);

        // asynchronous reset mid-line
        do_vsync();
        send_bytes(3);
        check("pre_reset_pix_data", 32'(pix_data), 32'h0001);
        #2;
        reset    = 1'b0;
        href     = 1'b0;
        m_active = 1'b0;
        m_y      = 0;
        #1;
        check("async_pix_data", 32'(pix_data), 32'h0);
        check("async_pix_xy", 32'({pix_x, pix_y}), 32'h0);
        check("async_flags", 32'({pix_valid, frame_start, line_done, frame_done, frame_err}), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();
        send_line(8);
        send_line(8);
        do_vsync();
        send_line(8);
        send_line(8);

        repeat (5) step();
        check("pixels_left", 32'(exp_q.size()), 32'd0);
        check("events_left", 32'(ev_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
